fetch_unit: RTL and testbench

Instruction-fetch stage of the MIPS pipeline: owns the program counter, issues one-outstanding requests to instruction memory, and presents fetched instructions with their PC+4 to the IF/DEC pipeline register. Variable-latency memory responses are decoupled from decode stalls through a 2-entry output queue. Branch/jump redirects from later stages flush the queue and squash any in-flight response.

---
 rtl/fetch_pkg.sv | 9 +
 rtl/fetch_queue.sv | 28 ++
 rtl/fetch_unit.sv | 58 +++++
 tb/tb_fetch_unit.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction-fetch stage
package fetch_pkg;
  typedef enum logic [1:0] {IDLE, BUSY, SQUASH} fetch_state_t;
  localparam logic [31:0] NOP_INSTR = 32'h0;
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pcplus4;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: 2-entry FIFO of fetched instructions between imem and decode
module fetch_queue
  import fetch_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t din,
  output logic [1:0]   count,
  output fetch_entry_t head
);
  fetch_entry_t e1;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      count <= '0;
      head  <= '0;
      e1    <= '0;
    end else if (flush) begin
      count <= '0;
    end else begin
      count <= count + {1'b0, push} - {1'b0, pop};
      if (pop) head <= (push && count == 2'd1) ? din : e1;
      else if (push && count == 2'd0) head <= din;
      if (push && count == (pop ? 2'd2 : 2'd1)) e1 <= din;
    end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC, one-outstanding imem request FSM and credit logic feeding IF/DEC
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr_IF,
  output logic [31:0] pcplus4_IF,
  output logic        valid_IF
);
  fetch_state_t state, state_nxt;
  logic [31:0]  pc;
  logic [1:0]   count, occ_next;
  logic         push, pop;
  fetch_entry_t din, head;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      pc    <= RESET_PC;
    end else begin
      state <= state_nxt;
      pc    <= redirect ? (redirect_pc & 32'hFFFF_FFFC) : imem_req ? pc + 32'd4 : pc;
    end
  // Any outstanding request that has not answered yet must be squashed on redirect.
  always_comb begin
    push      = imem_rvalid && state == BUSY && !redirect;
    pop       = valid_IF && !stall && !redirect;
    occ_next  = count + {1'b0, push} - {1'b0, pop};
    imem_req  = !reset && !redirect && (state == IDLE || imem_rvalid) && occ_next < 2'd2;
    state_nxt = redirect ? ((state != IDLE && !imem_rvalid) ? SQUASH : IDLE)
              : imem_req ? BUSY
              : (imem_rvalid && state != IDLE) ? IDLE : state;
    din       = '{instr: imem_rdata, pcplus4: pc};
  end
  fetch_queue u_queue (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .flush (redirect),
    .din   (din),
    .count (count),
    .head  (head)
  );
  assign imem_addr  = pc;
  assign valid_IF   = count != 2'd0;
  assign instr_IF   = valid_IF ? head.instr : NOP_INSTR;
  assign pcplus4_IF = valid_IF ? head.pcplus4 : 32'h0;
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed fetch scenarios with a memory model and in-order scoreboard
module tb_fetch_unit;
  import fetch_pkg::*;
  logic        clk = 1'b0;
  logic        reset;
  logic        stall = 1'b0, redirect = 1'b0, imem_rvalid = 1'b0;
  logic [31:0] redirect_pc = 32'h0, imem_rdata = 32'h0;
  logic        imem_req, valid_IF;
  logic [31:0] imem_addr, instr_IF, pcplus4_IF;
  int          checks = 0, errors = 0, cyc = 0, lat = 1;
  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;
  mreq_t        mq[$];
  fetch_entry_t sb[$];
  fetch_entry_t e;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(32'h0)) dut (
    .clk         (clk),
    .reset       (reset),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .instr_IF    (instr_IF),
    .pcplus4_IF  (pcplus4_IF),
    .valid_IF    (valid_IF)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic nc();
    @(posedge clk);
    #1;
  endtask

  task automatic ne();
    @(negedge clk);
  endtask

  task automatic wait_req(input string tag);
    int n = 0;
    while (!imem_req && n < 20) begin
      nc();
      ne();
      n++;
    end
    chk(tag, {31'b0, imem_req}, 32'h1);
  endtask

  // Memory returns the request address as data after lat cycles; keeps answering aborted requests.
  always begin
    @(posedge clk);
    cyc++;
    #1;
    if (mq.size() > 0 && mq[0].due <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mq[0].addr;
      void'(mq.pop_front());
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = 32'hDEAD_BEEF;
    end
  end

  // Every issued request is expected to reach decode in order unless a redirect or reset kills it.
  always @(negedge clk) begin
    if (reset || redirect) sb.delete();
    else begin
      if (valid_IF && !stall) begin
        checks++;
        assert (sb.size() > 0) else begin
          errors++;
          $error("FAIL sb_underflow observed=%h expected=nonempty", instr_IF);
        end
        if (sb.size() > 0) begin
          e = sb.pop_front();
          chk("sb_instr", instr_IF, e.instr);
          chk("sb_pcplus4", pcplus4_IF, e.pcplus4);
        end
      end
      if (imem_req) begin
        sb.push_back('{instr: imem_addr, pcplus4: imem_addr + 32'd4});
        mq.push_back('{imem_addr, cyc + lat});
      end
    end
  end

  initial begin
    #20000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    repeat (2) nc();
    ne();
    chk("rst_req", {31'b0, imem_req}, 32'h0);
    chk("rst_valid", {31'b0, valid_IF}, 32'h0);
    chk("rst_instr", instr_IF, 32'h0);
    chk("rst_pcplus4", pcplus4_IF, 32'h0);
    nc();
    reset = 1'b0;
    ne();
    for (int k = 0; k < 6; k++) begin
      if (k > 0) begin
        nc();
        ne();
      end
      chk("seq_req", {31'b0, imem_req}, 32'h1);
      chk("seq_addr", imem_addr, 32'(4 * k));
      if (k >= 2) begin
        chk("seq_instr", instr_IF, 32'(4 * (k - 2)));
        chk("seq_pcplus4", pcplus4_IF, 32'(4 * (k - 1)));
      end
    end
    for (int k = 0; k < 4; k++) begin
      nc();
      if (k == 0) stall = 1'b1;
      ne();
      chk("stall_req", {31'b0, imem_req}, 32'h0);
      chk("stall_hold", instr_IF, 32'h10);
      chk("stall_valid", {31'b0, valid_IF}, 32'h1);
    end
    nc();
    stall = 1'b0;
    ne();
    chk("release_req", {31'b0, imem_req}, 32'h1);
    chk("release_addr", imem_addr, 32'h18);
    chk("release_instr", instr_IF, 32'h10);
    repeat (4) begin
      nc();
      ne();
    end
    nc();
    lat = 3;
    ne();
    wait_req("l3_req");
    nc();
    redirect = 1'b1;
    redirect_pc = 32'h100;
    ne();
    chk("redir_req", {31'b0, imem_req}, 32'h0);
    nc();
    redirect = 1'b0;
    ne();
    chk("squash_req", {31'b0, imem_req}, 32'h0);
    chk("squash_valid", {31'b0, valid_IF}, 32'h0);
    chk("squash_instr", instr_IF, 32'h0);
    chk("squash_pcplus4", pcplus4_IF, 32'h0);
    nc();
    ne();
    chk("target_req", {31'b0, imem_req}, 32'h1);
    chk("target_addr", imem_addr, 32'h100);
    chk("target_valid", {31'b0, valid_IF}, 32'h0);
    repeat (3) begin
      nc();
      ne();
    end
    nc();
    ne();
    chk("target_instr", instr_IF, 32'h100);
    chk("target_pcplus4", pcplus4_IF, 32'h104);
    nc();
    lat = 1;
    ne();
    wait_req("l1_req");
    nc();
    redirect = 1'b1;
    stall = 1'b1;
    redirect_pc = 32'h200;
    ne();
    chk("rs_req", {31'b0, imem_req}, 32'h0);
    nc();
    redirect = 1'b0;
    ne();
    chk("rs_next_req", {31'b0, imem_req}, 32'h1);
    chk("rs_next_addr", imem_addr, 32'h200);
    chk("rs_flushed", {31'b0, valid_IF}, 32'h0);
    nc();
    stall = 1'b0;
    ne();
    chk("rs_addr2", imem_addr, 32'h204);
    nc();
    ne();
    chk("rs_instr", instr_IF, 32'h200);
    chk("rs_pcplus4", pcplus4_IF, 32'h204);
    nc();
    redirect = 1'b1;
    redirect_pc = 32'hFFFF_FFFE;
    ne();
    nc();
    redirect = 1'b0;
    ne();
    wait_req("wrap_req");
    chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
    nc();
    ne();
    chk("wrap_req0", {31'b0, imem_req}, 32'h1);
    chk("wrap_addr0", imem_addr, 32'h0);
    nc();
    ne();
    chk("wrap_instr", instr_IF, 32'hFFFF_FFFC);
    chk("wrap_pcplus4", pcplus4_IF, 32'h0);
    nc();
    lat = 3;
    ne();
    wait_req("pre_rst_req");
    nc();
    reset = 1'b1;
    ne();
    chk("mid_rst_req", {31'b0, imem_req}, 32'h0);
    chk("mid_rst_valid", {31'b0, valid_IF}, 32'h0);
    chk("mid_rst_instr", instr_IF, 32'h0);
    nc();
    ne();
    nc();
    reset = 1'b0;
    ne();
    chk("post_rst_req", {31'b0, imem_req}, 32'h1);
    chk("post_rst_addr", imem_addr, 32'h0);
    nc();
    ne();
    chk("late_ignored", {31'b0, valid_IF}, 32'h0);
    repeat (2) begin
      nc();
      ne();
    end
    nc();
    ne();
    chk("post_rst_instr", instr_IF, 32'h0);
    chk("post_rst_pcplus4", pcplus4_IF, 32'h4);
    chk("post_rst_valid", {31'b0, valid_IF}, 32'h1);
    repeat (6) begin
      nc();
      ne();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
